// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: clears registers 1..2**AW-1 after reset, then
// round-robins two writeback requesters onto a single registered write port.
module regfile_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] di3,
  output logic            we3,
  output logic            init_done
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [AW-1:0] IDX_FIRST = {{(AW-1){1'b0}}, 1'b1};

  state_e          state, state_nxt;
  logic [AW-1:0]   idx;
  logic            ptr;
  logic [1:0]      gnt;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // ptr names the requester that wins when both are valid
  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    case (state)
      INIT: if (&idx) state_nxt = RUN;
      RUN: begin
        if (req0_valid && (!req1_valid || !ptr)) gnt[0] = 1'b1;
        else if (req1_valid)                     gnt[1] = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign sel_addr   = gnt[1] ? req1_addr : req0_addr;
  assign sel_data   = gnt[1] ? req1_data : req0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= IDX_FIRST;
      ptr       <= 1'b0;
      a3        <= '0;
      di3       <= '0;
      we3       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          a3  <= idx;
          di3 <= '0;
          we3 <= 1'b1;
          idx <= idx + 1'b1;
          if (&idx) init_done <= 1'b1;
        end
        RUN: begin
          if (|gnt) begin
            a3  <= sel_addr;
            di3 <= sel_data;
            // x0 is hardwired: handshake completes but nothing is written
            we3 <= (sel_addr != '0);
            ptr <= gnt[0];
          end else begin
            we3 <= 1'b0;
          end
        end
        default: we3 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected register-file writes, a negedge
// monitor checks every we3 pulse against the queue.
module tb_regfile_write_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
  logic [XLEN-1:0] req0_data = '0, req1_data = '0;
  logic            req0_ready, req1_ready;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] di3;
  logic            we3, init_done;

  int vectors = 0;
  int errors  = 0;
  wr_t exp_q[$];

  regfile_write_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .a3(a3), .di3(di3), .we3(we3), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && we3) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got a3=%0d di3=%h, required no write", a3, di3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (a3 !== e.a || di3 !== e.d) begin
          errors++;
          $display("FAIL write: got a3=%0d di3=%h, required a3=%0d di3=%h", a3, di3, e.a, e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // one RUN cycle: drive requests, check grant, queue expected write, clock it
  task automatic cyc(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                     input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                     input logic g0, input logic g1,
                     input logic [AW-1:0] ea, input logic [XLEN-1:0] ed, input logic ewr);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    check("grant", {62'd0, req1_ready, req0_ready}, {62'd0, g1, g0});
    if (ewr) push(ea, ed);
    tick();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_we3"}, {63'd0, we3}, 64'd0);
    check({tag, "_a3_di3"}, {27'd0, a3, di3}, 64'd0);
    check({tag, "_init_done"}, {63'd0, init_done}, 64'd0);
    check({tag, "_ready"}, {62'd0, req1_ready, req0_ready}, 64'd0);
  endtask

  initial begin
    // hold both valids during reset and sweep: readies must stay low
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h5678;
    #2;
    reset_checks("por");
    @(negedge clk);
    reset = 1'b0;

    // partial sweep, then reset pulse at idx=10
    for (int i = 1; i <= 10; i++) begin
      push(AW'(i), '0);
      tick();
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset_checks("mid_sweep_rst");
    @(negedge clk);
    reset = 1'b0;

    // full sweep from idx=1
    for (int i = 1; i <= 31; i++) begin
      push(AW'(i), '0);
      check("sweep_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
      check("sweep_init_done", {63'd0, init_done}, 64'd0);
      tick();
    end
    check("init_done_set", {63'd0, init_done}, 64'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // req0 alone: addr 1, data 69
    cyc(1, 5'd1, 32'd69, 0, 5'd0, 32'd0, 1, 0, 5'd1, 32'd69, 1);
    // idle: no write, outputs hold
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
    check("idle_we3", {63'd0, we3}, 64'd0);
    check("idle_hold", {27'd0, a3, di3}, {27'd0, 5'd1, 32'd69});
    // both valid after req0 grant: req1 first, then alternate 0,1,0,1
    cyc(1, 5'd2, 32'd10, 1, 5'd3, 32'd20, 0, 1, 5'd3, 32'd20, 1);
    cyc(1, 5'd2, 32'd10, 1, 5'd3, 32'd21, 1, 0, 5'd2, 32'd10, 1);
    cyc(1, 5'd2, 32'd11, 1, 5'd3, 32'd21, 0, 1, 5'd3, 32'd21, 1);
    cyc(1, 5'd2, 32'd11, 1, 5'd3, 32'd22, 1, 0, 5'd2, 32'd11, 1);
    cyc(1, 5'd2, 32'd12, 1, 5'd3, 32'd22, 0, 1, 5'd3, 32'd22, 1);
    // req1 to x0: accepted, no write
    cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, 1, 5'd0, 32'd0, 0);
    check("x0_we3", {63'd0, we3}, 64'd0);
    // single requester streaming: granted every cycle
    cyc(0, 5'd0, 32'd0, 1, 5'd31, 32'hDEAD_BEEF, 0, 1, 5'd31, 32'hDEAD_BEEF, 1);
    cyc(0, 5'd0, 32'd0, 1, 5'd30, 32'hCAFE_F00D, 0, 1, 5'd30, 32'hCAFE_F00D, 1);
    cyc(0, 5'd0, 32'd0, 1, 5'd29, 32'h0000_0005, 0, 1, 5'd29, 32'h0000_0005, 1);
    // ptr is now 0: both valid -> req0
    cyc(1, 5'd4, 32'd44, 1, 5'd5, 32'd55, 1, 0, 5'd4, 32'd44, 1);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
    cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);

    // reset mid-RUN with a write pending on the output
    cyc(1, 5'd6, 32'd66, 0, 5'd0, 32'd0, 1, 0, 5'd6, 32'd66, 1);
    @(negedge clk);
    #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    reset_checks("run_rst");
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("restart_a3", {27'd0, we3, a3, di3}, {27'd0, 1'b1, 5'd1, 32'd0});
    push(5'd1, '0);
    @(negedge clk);
    #1;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
